// File: rtl/ppfifo_stream_source_if.sv
// Ping-pong FIFO read port plus the outgoing valid/ready stream, bundled for the stream source.
// The master modport is the stream source; the slave modport is the FIFO/sink side.
interface ppfifo_stream_source_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_rd_ready;
    logic                  o_rd_activate;
    logic [23:0]           i_rd_count;
    logic                  o_rd_stb;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_last;

    modport master (
        input  i_rd_ready,
        input  i_rd_count,
        input  i_rd_data,
        input  i_ready,
        output o_rd_activate,
        output o_rd_stb,
        output o_data,
        output o_valid,
        output o_last
    );

    modport slave (
        output i_rd_ready,
        output i_rd_count,
        output i_rd_data,
        output i_ready,
        input  o_rd_activate,
        input  o_rd_stb,
        input  o_data,
        input  o_valid,
        input  o_last
    );
endinterface

// File: rtl/ppfifo_stream_source.sv
// Claims a ready ping-pong FIFO buffer, drains its advertised word count and
// presents the words on a valid/ready stream with a last flag on the final word.
module ppfifo_stream_source #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_enable,
    output logic                          o_busy,
    ppfifo_stream_source_if.master        bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVATE = 2'd1,
        ST_STREAM   = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [23:0]           remaining_q, remaining_d;
    logic                  rd_activate_q, rd_activate_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  load;

    // Word counter floors at zero so a stray decrement can never wrap to 24'hFFFFFF.
    function automatic logic [23:0] dec_floor(input logic [23:0] v);
        return (v == 24'd0) ? 24'd0 : v - 24'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        rd_activate_d = rd_activate_q;
        data_d        = data_q;
        valid_d       = valid_q;
        last_d        = last_q;
        load          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_enable && bus.i_rd_ready && !rd_activate_q) begin
                    rd_activate_d = 1'b1;
                    remaining_d   = bus.i_rd_count;
                    state_d       = ST_ACTIVATE;
                end
            end
            ST_ACTIVATE: begin
                state_d = (remaining_q == 24'd0) ? ST_RELEASE : ST_STREAM;
            end
            ST_STREAM: begin
                load = (remaining_q != 24'd0) && (!valid_q || bus.i_ready);
                if (load) begin
                    remaining_d = dec_floor(remaining_q);
                end
                if (remaining_d == 24'd0) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                rd_activate_d = 1'b0;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stalled word holds; an accepted word is replaced or retired.
        if (load) begin
            data_d  = bus.i_rd_data;
            valid_d = 1'b1;
            last_d  = (remaining_q == 24'd1);
        end else if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            remaining_q   <= 24'd0;
            rd_activate_q <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            rd_activate_q <= rd_activate_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            last_q        <= last_d;
        end
    end

    assign bus.o_rd_activate = rd_activate_q;
    assign bus.o_rd_stb      = load;
    assign bus.o_data        = data_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_last        = last_q;
    assign o_busy            = (state_q != ST_IDLE) || valid_q;

endmodule

// File: tb/tb_ppfifo_stream_source.sv
// Directed bench for ppfifo_stream_source: a small ping-pong FIFO read-port model
// feeds the source, and a stream monitor records every accepted beat.
module tb_ppfifo_stream_source;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic i_enable;
    logic o_busy;

    ppfifo_stream_source_if #(.DATA_WIDTH(DW)) bus ();

    ppfifo_stream_source #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_enable (i_enable),
        .o_busy   (o_busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // FIFO model storage: written only by the stimulus block.
    logic [DW-1:0] mem     [0:127];
    logic [23:0]   cnt_mem [0:31];
    logic [6:0]    wr_ptr = 7'd0;
    logic [4:0]    n_bufs = 5'd0;

    // FIFO model read side: owned by the clocked process below.
    logic [6:0]    rd_ptr  = 7'd0;
    logic [4:0]    buf_ptr = 5'd0;

    assign bus.i_rd_ready = (buf_ptr != n_bufs);
    assign bus.i_rd_count = bus.i_rd_ready ? cnt_mem[buf_ptr] : 24'd0;
    assign bus.i_rd_data  = mem[rd_ptr];

    // A buffer is handed over on the edge where an idle, enabled source sees it ready.
    always @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= wr_ptr;
            buf_ptr <= n_bufs;
        end else begin
            if (bus.o_rd_stb) rd_ptr <= rd_ptr + 7'd1;
            if (i_enable && bus.i_rd_ready && !bus.o_rd_activate) buf_ptr <= buf_ptr + 5'd1;
        end
    end

    // Stream monitor.
    logic [DW-1:0] beat_data [0:63];
    logic          beat_last [0:63];
    int            beat_n   = 0;
    int            stb_n    = 0;
    int            act_n    = 0;
    int            valid_n  = 0;
    int            hold_err = 0;
    int            stb_err  = 0;
    int            low_run  = 0;
    int            last_gap = 0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;
    logic          last_prev = 1'b0;

    always @(posedge clk) begin
        if (bus.o_valid && bus.i_ready) begin
            beat_data[beat_n[5:0]] <= bus.o_data;
            beat_last[beat_n[5:0]] <= bus.o_last;
            beat_n <= beat_n + 1;
        end
        if (bus.o_rd_stb)      stb_n   <= stb_n + 1;
        if (bus.o_rd_activate) act_n   <= act_n + 1;
        if (bus.o_valid)       valid_n <= valid_n + 1;
        if (bus.o_rd_stb && (!bus.o_rd_activate || (bus.o_valid && !bus.i_ready)))
            stb_err <= stb_err + 1;
        if (hold_prev && (!bus.o_valid || bus.o_data !== data_prev || bus.o_last !== last_prev))
            hold_err <= hold_err + 1;
        hold_prev <= bus.o_valid && !bus.i_ready && !rst;
        data_prev <= bus.o_data;
        last_prev <= bus.o_last;
        if (bus.o_rd_activate) begin
            if (low_run != 0) last_gap <= low_run;
            low_run <= 0;
        end else begin
            low_run <= low_run + 1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 7'd1;
    endtask

    task automatic push_buf(input logic [23:0] count, input logic [DW-1:0] base);
        for (int i = 0; i < int'(count); i++) push_word(base + DW'(i));
        cnt_mem[n_bufs] = count;
        n_bufs = n_bufs + 5'd1;
    endtask

    task automatic check_beats(input string tag, input int b0, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            int k;
            k = b0 + i;
            check($sformatf("%s_data%0d", tag, i), 64'(beat_data[k[5:0]]), 64'(base + DW'(i)));
            check($sformatf("%s_last%0d", tag, i), 64'(beat_last[k[5:0]]), 64'(i == n - 1));
        end
    endtask

    initial begin
        int b0, s0, a0, v0, h0, e0;
        logic [3:0] pat;

        rst          = 1'b1;
        i_enable     = 1'b0;
        bus.i_ready  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_activate", 64'(bus.o_rd_activate), 64'd0);
        check("rst_stb",      64'(bus.o_rd_stb),      64'd0);
        check("rst_valid",    64'(bus.o_valid),       64'd0);
        check("rst_last",     64'(bus.o_last),        64'd0);
        check("rst_data",     64'(bus.o_data),        64'd0);
        check("rst_busy",     64'(o_busy),            64'd0);
        rst = 1'b0;
        tick();

        // Test 1: count=4, sink always ready
        b0 = beat_n; s0 = stb_n;
        push_buf(24'd4, 32'hA000_0000);
        i_enable    = 1'b1;
        bus.i_ready = 1'b1;
        tick();
        check("t1_act_latency", 64'(bus.o_rd_activate), 64'd1);
        check("t1_settle_stb",  64'(bus.o_rd_stb),      64'd0);
        check("t1_settle_vld",  64'(bus.o_valid),       64'd0);
        tick();
        check("t1_first_stb",   64'(bus.o_rd_stb),      64'd1);
        check("t1_first_vld0",  64'(bus.o_valid),       64'd0);
        tick();
        check("t1_beat0_vld",   64'(bus.o_valid),       64'd1);
        check("t1_beat0_data",  64'(bus.o_data),        64'hA000_0000);
        check("t1_beat0_last",  64'(bus.o_last),        64'd0);
        tick();
        tick();
        check("t1_beat2_data",  64'(bus.o_data),        64'hA000_0002);
        tick();
        check("t1_beat3_data",  64'(bus.o_data),        64'hA000_0003);
        check("t1_beat3_last",  64'(bus.o_last),        64'd1);
        check("t1_release_stb", 64'(bus.o_rd_stb),      64'd0);
        check("t1_release_act", 64'(bus.o_rd_activate), 64'd1);
        tick();
        check("t1_act_fall",    64'(bus.o_rd_activate), 64'd0);
        check("t1_vld_fall",    64'(bus.o_valid),       64'd0);
        check("t1_busy_idle",   64'(o_busy),            64'd0);
        check("t1_beats",       64'(beat_n - b0),       64'd4);
        check("t1_strobes",     64'(stb_n - s0),        64'd4);
        check_beats("t1", b0, 4, 32'hA000_0000);

        // Test 2: count=4, sink ready pattern 1,0,0,1
        b0 = beat_n; s0 = stb_n; h0 = hold_err; e0 = stb_err;
        push_buf(24'd4, 32'hB000_0000);
        pat = 4'b1001;
        for (int i = 0; i < 24; i++) begin
            bus.i_ready = pat[i % 4];
            tick();
        end
        bus.i_ready = 1'b1;
        repeat (3) tick();
        check("t2_beats",     64'(beat_n - b0),     64'd4);
        check("t2_strobes",   64'(stb_n - s0),      64'd4);
        check("t2_hold",      64'(hold_err - h0),   64'd0);
        check("t2_stb_stall", 64'(stb_err - e0),    64'd0);
        check("t2_busy_idle", 64'(o_busy),          64'd0);
        check_beats("t2", b0, 4, 32'hB000_0000);

        // Test 3: count=1
        b0 = beat_n; s0 = stb_n; v0 = valid_n;
        push_buf(24'd1, 32'hC000_0000);
        repeat (8) tick();
        check("t3_beats",   64'(beat_n - b0),   64'd1);
        check("t3_strobes", 64'(stb_n - s0),    64'd1);
        check("t3_valids",  64'(valid_n - v0),  64'd1);
        check_beats("t3", b0, 1, 32'hC000_0000);

        // Test 4: count=0
        b0 = beat_n; s0 = stb_n; v0 = valid_n; a0 = act_n;
        push_buf(24'd0, 32'h0);
        repeat (8) tick();
        check("t4_strobes",  64'(stb_n - s0),   64'd0);
        check("t4_valids",   64'(valid_n - v0), 64'd0);
        check("t4_act_len",  64'((act_n - a0) >= 2 && (act_n - a0) <= 3), 64'd1);
        check("t4_act_low",  64'(bus.o_rd_activate), 64'd0);
        check("t4_busy",     64'(o_busy),       64'd0);

        // Test 5: two count=3 buffers back to back
        b0 = beat_n; s0 = stb_n;
        push_buf(24'd3, 32'hD000_0000);
        push_buf(24'd3, 32'hE000_0000);
        repeat (16) tick();
        check("t5_beats",    64'(beat_n - b0), 64'd6);
        check("t5_strobes",  64'(stb_n - s0),  64'd6);
        check("t5_gap",      64'(last_gap >= 1), 64'd1);
        check("t5_drained",  64'(bus.i_rd_ready), 64'd0);
        check_beats("t5a", b0,     3, 32'hD000_0000);
        check_beats("t5b", b0 + 3, 3, 32'hE000_0000);

        // Test 6: reset during beat 2 of a count=8 buffer, then a clean count=2 buffer
        push_buf(24'd8, 32'hF000_0000);
        repeat (4) tick();
        check("t6_beat2_data", 64'(bus.o_data),  64'hF000_0001);
        check("t6_beat2_vld",  64'(bus.o_valid), 64'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_act",   64'(bus.o_rd_activate), 64'd0);
        check("t6_rst_stb",   64'(bus.o_rd_stb),      64'd0);
        check("t6_rst_valid", 64'(bus.o_valid),       64'd0);
        check("t6_rst_last",  64'(bus.o_last),        64'd0);
        check("t6_rst_data",  64'(bus.o_data),        64'd0);
        check("t6_rst_busy",  64'(o_busy),            64'd0);
        rst = 1'b0;
        b0 = beat_n; s0 = stb_n;
        push_buf(24'd2, 32'h6000_0000);
        repeat (10) tick();
        check("t6_beats",   64'(beat_n - b0), 64'd2);
        check("t6_strobes", 64'(stb_n - s0),  64'd2);
        check_beats("t6", b0, 2, 32'h6000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
